// File: rtl/midi_pkg.sv
// Shared constants, state encodings and message record for the outbound MIDI path.
package midi_pkg;

    localparam int         MIDI_BAUD       = 31250;
    localparam logic [3:0] STATUS_NOTE_ON  = 4'h9;
    localparam logic [3:0] STATUS_NOTE_OFF = 4'h8;
    localparam int         ENTRY_W         = 15;

    typedef enum logic [1:0] {
        MSG_IDLE,
        MSG_STATUS,
        MSG_KEY,
        MSG_VEL
    } msg_state_e;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    typedef struct packed {
        logic       note_on;
        logic [6:0] key;
        logic [6:0] vel;
    } msg_entry_t;

    function automatic logic [7:0] status_byte(input logic on, input logic [3:0] ch);
        return {(on ? STATUS_NOTE_ON : STATUS_NOTE_OFF), ch};
    endfunction

endpackage

// File: rtl/midi_uart_byte_tx.sv
// 8N1 byte serializer; a byte loaded in the last stop-bit cycle follows with no idle gap.
module midi_uart_byte_tx
    import midi_pkg::*;
#(
    parameter int CLKS_PER_BIT = 2080
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] byte_in,
    input  logic       byte_load,
    output logic       serial,
    output logic       byte_done,
    output logic       tx_busy
);

    localparam int               CNT_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       data_q, data_d;
    logic             serial_q, serial_d;
    logic             bit_end;

    assign bit_end = (cnt_q == CNT_MAX);

    always_comb begin
        state_d   = state_q;
        cnt_d     = bit_end ? '0 : cnt_q + 1'b1;
        bit_d     = bit_q;
        data_d    = data_q;
        byte_done = 1'b0;
        unique case (state_q)
            TX_IDLE: begin
                cnt_d = '0;
                if (byte_load) begin
                    state_d = TX_START;
                    data_d  = byte_in;
                end
            end
            TX_START: begin
                if (bit_end) begin
                    state_d = TX_DATA;
                    bit_d   = 3'd0;
                end
            end
            TX_DATA: begin
                if (bit_end) begin
                    if (bit_q == 3'd7) state_d = TX_STOP;
                    else               bit_d   = bit_q + 1'b1;
                end
            end
            TX_STOP: begin
                if (bit_end) begin
                    byte_done = 1'b1;
                    if (byte_load) begin
                        state_d = TX_START;
                        data_d  = byte_in;
                    end else begin
                        state_d = TX_IDLE;
                    end
                end
            end
        endcase

        // Line level follows the next state so the output stays registered.
        serial_d = 1'b1;
        unique case (state_d)
            TX_START: serial_d = 1'b0;
            TX_DATA:  serial_d = data_d[bit_d];
            default:  serial_d = 1'b1;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= TX_IDLE;
            cnt_q    <= '0;
            bit_q    <= 3'd0;
            serial_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            serial_q <= serial_d;
        end
    end

    always_ff @(posedge clock) begin
        data_q <= data_d;
    end

    assign serial  = serial_q;
    assign tx_busy = (state_q != TX_IDLE);

endmodule

// File: rtl/midi_tx.sv
// MIDI note-on/off transmitter: message FIFO, byte sequencer with running status, UART serializer.
module midi_tx
    import midi_pkg::*;
#(
    parameter int CLKS_PER_BIT   = 2080,
    parameter int CHANNEL        = 0,
    parameter int DEPTH          = 4,
    parameter int LOG            = 2,
    parameter int RUNNING_STATUS = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       msg_valid,
    output logic       msg_ready,
    input  logic       note_on,
    input  logic [6:0] key_index,
    input  logic [6:0] velocity,
    output logic       serial,
    output logic       busy,
    output logic       overflow
);

    localparam logic [3:0] CHAN = 4'(CHANNEL);
    localparam logic [LOG:0] FULL = (LOG + 1)'(DEPTH);

    msg_entry_t     mem_q [DEPTH];
    logic [LOG-1:0] wr_ptr_q, rd_ptr_q;
    logic [LOG:0]   count_q;
    logic           overflow_q;
    logic           push, pop, fifo_empty;
    msg_entry_t     head;

    assign msg_ready  = (count_q != FULL);
    assign fifo_empty = (count_q == '0);
    assign push       = msg_valid & msg_ready;
    assign head       = mem_q[rd_ptr_q];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
            if (msg_valid && !msg_ready) overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= {note_on, key_index, velocity};
    end

    msg_state_e seq_q, seq_d;
    logic       issued_q, issued_d;
    logic       last_vld_q, last_vld_d;
    logic [7:0] last_stat_q, last_stat_d;
    logic [7:0] stat_q, stat_d;
    msg_entry_t cur_q, cur_d;
    logic [7:0] next_stat, byte_val;
    logic       skip_stat, byte_load, byte_done, tx_busy;

    always_comb begin
        seq_d       = seq_q;
        issued_d    = issued_q;
        last_vld_d  = last_vld_q;
        last_stat_d = last_stat_q;
        stat_d      = stat_q;
        cur_d       = cur_q;
        pop         = 1'b0;
        byte_load   = 1'b0;
        byte_val    = 8'h00;
        next_stat   = status_byte(head.note_on, CHAN);
        skip_stat   = (RUNNING_STATUS != 0) && last_vld_q && (next_stat == last_stat_q);

        unique case (seq_q)
            MSG_IDLE: begin
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    cur_d    = head;
                    stat_d   = next_stat;
                    issued_d = 1'b0;
                    seq_d    = skip_stat ? MSG_KEY : MSG_STATUS;
                end
            end
            MSG_STATUS: begin
                if (!issued_q) begin
                    byte_load = 1'b1;
                    byte_val  = stat_q;
                    issued_d  = 1'b1;
                end else if (byte_done) begin
                    last_stat_d = stat_q;
                    last_vld_d  = 1'b1;
                    byte_load   = 1'b1;
                    byte_val    = {1'b0, cur_q.key};
                    seq_d       = MSG_KEY;
                end
            end
            MSG_KEY: begin
                if (!issued_q) begin
                    byte_load = 1'b1;
                    byte_val  = {1'b0, cur_q.key};
                    issued_d  = 1'b1;
                end else if (byte_done) begin
                    byte_load = 1'b1;
                    byte_val  = {1'b0, cur_q.vel};
                    seq_d     = MSG_VEL;
                end
            end
            MSG_VEL: begin
                if (!issued_q) begin
                    byte_load = 1'b1;
                    byte_val  = {1'b0, cur_q.vel};
                    issued_d  = 1'b1;
                end else if (byte_done) begin
                    // Chain straight into the next queued message so frames stay back-to-back.
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        cur_d     = head;
                        stat_d    = next_stat;
                        byte_load = 1'b1;
                        byte_val  = skip_stat ? {1'b0, head.key} : next_stat;
                        seq_d     = skip_stat ? MSG_KEY : MSG_STATUS;
                    end else begin
                        issued_d = 1'b0;
                        seq_d    = MSG_IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            seq_q      <= MSG_IDLE;
            issued_q   <= 1'b0;
            last_vld_q <= 1'b0;
        end else begin
            seq_q      <= seq_d;
            issued_q   <= issued_d;
            last_vld_q <= last_vld_d;
        end
    end

    always_ff @(posedge clock) begin
        last_stat_q <= last_stat_d;
        stat_q      <= stat_d;
        cur_q       <= cur_d;
    end

    midi_uart_byte_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte_tx (
        .clock    (clock),
        .reset    (reset),
        .byte_in  (byte_val),
        .byte_load(byte_load),
        .serial   (serial),
        .byte_done(byte_done),
        .tx_busy  (tx_busy)
    );

    assign busy     = (count_q != '0) | (seq_q != MSG_IDLE) | tx_busy;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_midi_tx.sv
// Bench for midi_tx: two instances (channel 0 with running status, channel 5 without) fed the same requests.
module tb_midi_tx;

    localparam int C = 8;
    localparam int NB = 128;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       msg_valid;
    logic       note_on;
    logic [6:0] key_index;
    logic [6:0] velocity;
    logic       msg_ready_a, serial_a, busy_a, overflow_a;
    logic       msg_ready_b, serial_b, busy_b, overflow_b;

    always #5 clk = ~clk;

    midi_tx #(.CLKS_PER_BIT(C), .CHANNEL(0), .DEPTH(4), .LOG(2), .RUNNING_STATUS(1)) dut_a (
        .clock(clk), .reset(rst_n), .msg_valid(msg_valid), .msg_ready(msg_ready_a),
        .note_on(note_on), .key_index(key_index), .velocity(velocity),
        .serial(serial_a), .busy(busy_a), .overflow(overflow_a)
    );

    midi_tx #(.CLKS_PER_BIT(C), .CHANNEL(5), .DEPTH(4), .LOG(2), .RUNNING_STATUS(0)) dut_b (
        .clock(clk), .reset(rst_n), .msg_valid(msg_valid), .msg_ready(msg_ready_b),
        .note_on(note_on), .key_index(key_index), .velocity(velocity),
        .serial(serial_b), .busy(busy_b), .overflow(overflow_b)
    );

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Line receivers: sample mid-bit on the falling clock edge
    logic [7:0] rx_byte [2][NB];
    int         rx_time [2][NB];
    int         rx_n    [2];
    int         rx_ferr [2];
    logic       rx_act  [2];
    int         rx_ph   [2];
    int         rx_t0   [2];
    logic [7:0] rx_sh   [2];
    logic [1:0] ser_v;

    assign ser_v = {serial_b, serial_a};

    initial begin
        for (int k = 0; k < 2; k++) begin
            rx_n[k] = 0; rx_ferr[k] = 0; rx_act[k] = 1'b0; rx_ph[k] = 0; rx_t0[k] = 0; rx_sh[k] = 8'h00;
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (rst_n !== 1'b1) begin
                    rx_act[k] = 1'b0;
                end else if (!rx_act[k]) begin
                    if (ser_v[k] == 1'b0) begin
                        rx_act[k] = 1'b1; rx_ph[k] = 0; rx_t0[k] = cyc;
                    end
                end else begin
                    rx_ph[k]++;
                    if (rx_ph[k] % C == C / 2) begin
                        if (rx_ph[k] / C == 0) begin
                            if (ser_v[k] != 1'b0) begin rx_ferr[k]++; rx_act[k] = 1'b0; end
                        end else if (rx_ph[k] / C <= 8) begin
                            rx_sh[k][rx_ph[k] / C - 1] = ser_v[k];
                        end else begin
                            if (ser_v[k] != 1'b1) rx_ferr[k]++;
                            if (rx_n[k] < NB) begin
                                rx_byte[k][rx_n[k]] = rx_sh[k];
                                rx_time[k][rx_n[k]] = rx_t0[k];
                            end
                            rx_n[k]++;
                            rx_act[k] = 1'b0;
                        end
                    end
                end
            end
        end
    end

    typedef struct packed {
        logic            is_on;
        logic [6:0]      key;
        logic [6:0]      vel;
        logic [1:0]      na;
        logic [2:0][7:0] ea;
        logic [1:0]      nb;
        logic [2:0][7:0] eb;
    } vec_t;

    vec_t vt [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_bytes(input string name, input int k, input int base, input int n,
                               input logic [63:0] e, input bit gap);
        check({name, "_count"}, rx_n[k] - base, n);
        for (int j = 0; j < n; j++) begin
            if (base + j < NB) begin
                check($sformatf("%s_byte%0d", name, j), {24'h0, rx_byte[k][base + j]}, {24'h0, e[8*j +: 8]});
                if (gap && j > 0)
                    check($sformatf("%s_gap%0d", name, j),
                          rx_time[k][base + j] - rx_time[k][base + j - 1], 10 * C);
            end
        end
    endtask

    task automatic send(input logic on, input logic [6:0] k, input logic [6:0] v);
        note_on = on; key_index = k; velocity = v; msg_valid = 1'b1;
        @(negedge clk);
        msg_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int limit);
        int n;
        n = 0;
        while ((busy_a || busy_b) && n < limit) begin
            @(negedge clk);
            n++;
        end
        check({name, "_idle_in_time"}, {31'h0, busy_a | busy_b}, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int base_a, base_b, n;
        rst_n = 1'b0; msg_valid = 1'b0; note_on = 1'b0; key_index = 7'd0; velocity = 7'd0;

        vt[0] = '{1'b1, 7'd60,  7'd100, 2'd3, 24'h643C90, 2'd3, 24'h643C95};
        vt[1] = '{1'b1, 7'd64,  7'd80,  2'd2, 24'h005040, 2'd3, 24'h504095};
        vt[2] = '{1'b0, 7'd60,  7'd0,   2'd3, 24'h003C80, 2'd3, 24'h003C85};
        vt[3] = '{1'b0, 7'd127, 7'd127, 2'd2, 24'h007F7F, 2'd3, 24'h7F7F85};
        vt[4] = '{1'b1, 7'd0,   7'd1,   2'd3, 24'h010090, 2'd3, 24'h010095};
        vt[5] = '{1'b1, 7'h55,  7'h2A,  2'd2, 24'h002A55, 2'd3, 24'h2A5595};

        repeat (3) @(negedge clk);
        check("rst_serial_a", serial_a, 1);
        check("rst_busy_a", busy_a, 0);
        check("rst_ready_a", msg_ready_a, 1);
        check("rst_overflow_a", overflow_a, 0);
        check("rst_serial_b", serial_b, 1);
        rst_n = 1'b1;
        @(negedge clk);

        // Single note-on: latency, message duration, byte content
        base_a = rx_n[0]; base_b = rx_n[1];
        send(1'b1, 7'd60, 7'd100);
        check("lat_edge0_a", serial_a, 1);
        @(negedge clk);
        check("lat_edge1_a", serial_a, 1);
        check("lat_edge1_b", serial_b, 1);
        @(negedge clk);
        check("lat_edge2_a", serial_a, 0);
        check("lat_edge2_b", serial_b, 0);
        n = 0;
        while (busy_a && n < 2000) begin @(negedge clk); n++; end
        check("busy_len_a", n, 30 * C);
        wait_idle("single", 2000);
        check_bytes("single_a", 0, base_a, 3, 64'h643C90, 1'b1);
        check_bytes("single_b", 1, base_b, 3, 64'h643C95, 1'b1);

        // Two messages on consecutive cycles: frames must be gapless across the message boundary
        do_reset();
        base_a = rx_n[0]; base_b = rx_n[1];
        send(1'b1, 7'd60, 7'd100);
        send(1'b1, 7'd64, 7'd80);
        wait_idle("b2b", 4000);
        check_bytes("b2b_a", 0, base_a, 5, 64'h0000005040643C90, 1'b1);
        check_bytes("b2b_b", 1, base_b, 6, 64'h0000504095643C95, 1'b1);

        // Table of single messages, each sent from idle
        do_reset();
        for (int i = 0; i < 6; i++) begin
            base_a = rx_n[0]; base_b = rx_n[1];
            send(vt[i].is_on, vt[i].key, vt[i].vel);
            wait_idle($sformatf("tbl%0d", i), 2000);
            check_bytes($sformatf("tbl%0d_a", i), 0, base_a, int'(vt[i].na), 64'(vt[i].ea), 1'b1);
            check_bytes($sformatf("tbl%0d_b", i), 1, base_b, int'(vt[i].nb), 64'(vt[i].eb), 1'b1);
        end
        check("tbl_no_overflow_a", overflow_a, 0);

        // Six pushes on consecutive cycles into a 4-deep FIFO
        do_reset();
        base_a = rx_n[0]; base_b = rx_n[1];
        for (int i = 0; i < 6; i++) begin
            note_on = 1'b1; key_index = 7'(10 + i); velocity = 7'(1 + i); msg_valid = 1'b1;
            check($sformatf("ovf_ready%0d_a", i), msg_ready_a, (i < 5) ? 1 : 0);
            if (i == 5) check("ovf_before_a", overflow_a, 0);
            @(negedge clk);
        end
        msg_valid = 1'b0;
        check("ovf_set_a", overflow_a, 1);
        check("ovf_set_b", overflow_b, 1);
        wait_idle("ovf", 8000);
        check("ovf_count_a", rx_n[0] - base_a, 11);
        check("ovf_count_b", rx_n[1] - base_b, 15);
        if (rx_n[0] - base_a == 11) begin
            check("ovf_lastkey_a", {24'h0, rx_byte[0][base_a + 9]}, 32'h0E);
            check("ovf_lastvel_a", {24'h0, rx_byte[0][base_a + 10]}, 32'h05);
        end
        check("ovf_sticky_a", overflow_a, 1);

        // Asynchronous reset during data bit 1 of the second byte
        do_reset();
        base_a = rx_n[0]; base_b = rx_n[1];
        send(1'b1, 7'd60, 7'd100);
        repeat (2 + 12 * C + C / 2) @(negedge clk);
        check("mid_line_low_a", serial_a, 0);
        check("mid_one_byte_a", rx_n[0] - base_a, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_serial_a", serial_a, 1);
        check("mid_rst_busy_a", busy_a, 0);
        check("mid_rst_ready_a", msg_ready_a, 1);
        check("mid_rst_serial_b", serial_b, 1);
        check("mid_rst_busy_b", busy_b, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        base_a = rx_n[0]; base_b = rx_n[1];
        send(1'b1, 7'd60, 7'd100);
        wait_idle("post_rst", 2000);
        check_bytes("post_rst_a", 0, base_a, 3, 64'h643C90, 1'b1);
        check_bytes("post_rst_b", 1, base_b, 3, 64'h643C95, 1'b1);

        check("framing_a", rx_ferr[0], 0);
        check("framing_b", rx_ferr[1], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/midi_tx.md
Name: midi_tx

Overview:
- Serial MIDI transmitter, the outbound counterpart of the keyboard receiver on JA[0]. Sends note-on and note-off messages from the 65 MHz domain, e.g. to echo played keys or drive an external synth.
- Queues requests in a small message FIFO.
- Serializes each message as 8N1 UART bytes at 31250 baud, with optional MIDI running status.

Parameters:
- CLKS_PER_BIT, 2080, clock cycles per bit (65 MHz / 31250 baud).
- CHANNEL, 0, MIDI channel (4 bits) placed in the status low nibble.
- DEPTH, 4, message FIFO entries (power of 2).
- LOG, 2, log2(DEPTH).
- RUNNING_STATUS, 1, 1 = omit a repeated status byte.

Ports:
- clock  in  1  system clock, 65 MHz.
- reset  in  1  asynchronous, active-low reset.
- msg_valid  in  1  request strobe; a message is accepted on a clock edge where msg_valid & msg_ready.
- msg_ready  out  1  FIFO not full.
- note_on  in  1  1 = note-on (status 0x9n), 0 = note-off (status 0x8n).
- key_index  in  7  MIDI key number (data byte 1).
- velocity  in  7  velocity (data byte 2).
- serial  out  1  UART line; idles high.
- busy  out  1  high while the FIFO is non-empty or a byte is on the line.
- overflow  out  1  sticky; set when msg_valid is high while msg_ready is low.

Behaviour:
- Reset (reset low, asynchronous): serial=1, busy=0, msg_ready=1, overflow=0. FIFO is emptied, last-status register is invalid, FSMs are IDLE. Reset mid-frame aborts the frame and returns the line high immediately.
- FIFO entries are {note_on, key_index, velocity}, 15 bits each.
  - Write pointer, read pointer and count are LOG-bit (count LOG+1).
  - msg_ready is derived from the registered count; there is no pass-through.
  - A push attempted while full is dropped and sets overflow, even if a pop occurs in the same cycle.
  - A simultaneous push and pop when not full leaves count unchanged.
- Message sequencer states: MSG_IDLE, MSG_STATUS, MSG_KEY, MSG_VEL.
  - MSG_IDLE: when the FIFO is non-empty, pop the head and compute status = {1'b1, note_on ? 3'b001 : 3'b000, CHANNEL[3:0]}.
  - If RUNNING_STATUS=1, the last status is valid and status equals it, go to MSG_KEY; otherwise go to MSG_STATUS.
  - Each byte state issues the byte to the serializer, then waits for byte_done.
  - MSG_STATUS sends status, then updates the last status and sets it valid. MSG_KEY sends {0,key}. MSG_VEL sends {0,vel}.
  - After MSG_VEL, return to MSG_IDLE, which can pop the next message the same cycle.
- Byte serializer states: TX_IDLE, TX_START, TX_DATA, TX_STOP.
  - Bit counter runs 0..CLKS_PER_BIT-1; bit index is 3 bits.
  - TX_START drives 0, TX_DATA drives data LSB first, TX_STOP drives 1. Each bit lasts exactly CLKS_PER_BIT cycles.
  - byte_done pulses for one cycle at the end of the stop bit.
  - A new byte is loaded the same cycle, so bytes within a message are back-to-back.
  - Frame length is 10*CLKS_PER_BIT = 20800 cycles.
- Latency: with the FIFO empty and both FSMs idle, serial falls exactly 2 cycles after the accepting edge (one cycle to write, one cycle to pop and load). serial is registered.
- Message durations: a full message is 3 frames = 62400 cycles; a running-status message is 2 frames = 41600 cycles.
- busy = (count != 0) | (sequencer != MSG_IDLE) | (serializer != TX_IDLE).
- Data bits 7 of key and velocity are forced to 0. Input values are never range-checked.
- overflow clears only on reset.

Decomposition:
- Shared package midi_pkg holds:
  - MIDI_BAUD = 31250;
  - STATUS_NOTE_ON = 4'h9 and STATUS_NOTE_OFF = 4'h8;
  - sequencer and serializer state encodings;
  - the FIFO entry width, 15.
- Sub-module midi_uart_byte_tx provides the CLKS_PER_BIT serializer: inputs byte_in and byte_load, outputs serial, byte_done and tx_busy. It is reusable by other outbound serial links.
- The FIFO and sequencer stay in midi_tx.

Test Plan:
- Single note-on (key 60, velocity 100, CHANNEL 0) after reset: serial falls 2 cycles after acceptance. Line decodes to bytes 0x90, 0x3C, 0x64, each 20800 cycles, LSB first. busy drops 62400 cycles after the first fall.
- Two note-ons back-to-back with RUNNING_STATUS=1, second key 64 velocity 80: bytes are 0x90 0x3C 0x64 0x40 0x50, with no gap between frames. With RUNNING_STATUS=0, 0x90 is repeated before 0x40.
- Note-on then note-off of key 60, velocity 0: a status byte 0x80 is sent for the second message because the status changed.
- Push 6 messages on consecutive cycles with DEPTH=4:
  - the first 5 are accepted, since one is popped after 1 cycle;
  - msg_ready is low on the 6th, that message is dropped, and overflow=1 stays set;
  - exactly 5 messages are emitted.
- Assert reset low mid-data-bit of the second byte: serial goes to 1 asynchronously, busy=0, msg_ready=1. After release, a new note is sent with its full status byte because the last status was invalidated.
- With CHANNEL=5, send a note-off of key 127, velocity 127: bytes are 0x85 0x7F 0x7F. Key 0x80 wrapping does not occur because inputs are 7 bits.
